// File: rtl/inst_fetch_queue_if.sv
// Fetch-to-decode handshake bundle for inst_fetch_queue.
// master = fetch/decode side driving the queue; slave = the queue itself.
interface inst_fetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic                     valid_i;
  logic                     ready_o;
  logic [ADDR_W-1:0]        instAddr_i;
  logic [INST_W-1:0]        inst_i;
  logic                     jumpFlag_i;
  logic                     valid_o;
  logic                     ready_i;
  logic [ADDR_W-1:0]        instAddr_o;
  logic [INST_W-1:0]        inst_o;
  logic [$clog2(DEPTH):0]   count_o;

  modport master (
    output valid_i, instAddr_i, inst_i, jumpFlag_i, ready_i,
    input  ready_o, valid_o, instAddr_o, inst_o, count_o
  );

  modport slave (
    input  valid_i, instAddr_i, inst_i, jumpFlag_i, ready_i,
    output ready_o, valid_o, instAddr_o, inst_o, count_o
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Decoupling FIFO between fetch and decode, flushed on jump/redirect.
// Optional INST_QUEUE_BYPASS_EN: zero-latency pass-through when the queue is empty.
module inst_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  inst_fetch_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic empty, push, pop, wr_en;

  assign empty     = (count == '0);
  // ready depends only on occupancy: a pop while full does not open a slot this cycle
  assign q.ready_o = (count != FULL);
  assign q.count_o = count;
  assign push      = q.valid_i & q.ready_o & ~q.jumpFlag_i;
  assign pop       = ~empty & ~q.jumpFlag_i & q.ready_i;

`ifdef INST_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass       = empty & q.valid_i & ~q.jumpFlag_i;
  // a bypassed entry taken by decode this cycle never touches storage
  assign wr_en        = push & ~(bypass & q.ready_i);
  assign q.valid_o    = (~empty | q.valid_i) & ~q.jumpFlag_i;
  assign q.instAddr_o = bypass ? q.instAddr_i : (empty ? '0 : addr_mem[rd_ptr]);
  assign q.inst_o     = bypass ? q.inst_i     : (empty ? '0 : inst_mem[rd_ptr]);
`else
  assign wr_en        = push;
  assign q.valid_o    = ~empty & ~q.jumpFlag_i;
  assign q.instAddr_o = empty ? '0 : addr_mem[rd_ptr];
  assign q.inst_o     = empty ? '0 : inst_mem[rd_ptr];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (q.jumpFlag_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // storage is not reset; reads are gated by count
  always_ff @(posedge clk) begin
    if (wr_en) begin
      addr_mem[wr_ptr] <= q.instAddr_i;
      inst_mem[wr_ptr] <= q.inst_i;
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: vector table plus flush/reset/full/bypass sequences.
module tb_inst_fetch_queue;
  localparam int DEPTH = 4;
`ifdef INST_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    bit          v, r, j;
    logic [31:0] a, i;
    bit          ev, er;
    int          ec;
    logic [31:0] ea, ei;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_pass = 0, n_total = 0, n_bound_fail = 0;
  bit   seen_jump = 1'b0, seen_old = 1'b0, post_reset = 1'b0;
  vec_t vecs[$];

  inst_fetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(32)) bus();
  inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .q(bus)
  );

  always #5 clk = ~clk;

  // occupancy must never exceed DEPTH
  always @(negedge clk) begin
    if (reset_n && int'(bus.count_o) > DEPTH) begin
      n_bound_fail++;
      $display("FAIL count_bound: count_o=%0d exceeds %0d", bus.count_o, DEPTH);
    end
  end

  always @(negedge clk) begin
    if (reset_n && bus.valid_o) begin
      if (bus.instAddr_o == 32'h3000) seen_jump = 1'b1;
      if (post_reset && (bus.instAddr_o == 32'h6000 || bus.instAddr_o == 32'h6004)) seen_old = 1'b1;
    end
  end

  function automatic vec_t mk(bit v, bit r, bit j, logic [31:0] a, logic [31:0] i,
                              bit ev, bit er, int ec, logic [31:0] ea, logic [31:0] ei);
    vec_t t;
    t.v = v; t.r = r; t.j = j; t.a = a; t.i = i;
    t.ev = ev; t.er = er; t.ec = ec; t.ea = ea; t.ei = ei;
    return t;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(bit v, bit r, bit j, logic [31:0] a, logic [31:0] i);
    bus.valid_i = v; bus.ready_i = r; bus.jumpFlag_i = j;
    bus.instAddr_i = a; bus.inst_i = i;
  endtask

  // drive inputs and move to the sampling point of the same cycle
  task automatic step(bit v, bit r, bit j, logic [31:0] a, logic [31:0] i);
    drive(v, r, j, a, i);
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);

    // fill with decode stalled; the 5th offer is refused
    vecs.push_back(mk(1,0,0,32'h1000,32'hA0, BYP,1,0, BYP ? 32'h1000 : 32'h0, BYP ? 32'hA0 : 32'h0));
    vecs.push_back(mk(1,0,0,32'h1004,32'hA1, 1,1,1, 32'h1000,32'hA0));
    vecs.push_back(mk(1,0,0,32'h1008,32'hA2, 1,1,2, 32'h1000,32'hA0));
    vecs.push_back(mk(1,0,0,32'h100C,32'hA3, 1,1,3, 32'h1000,32'hA0));
    vecs.push_back(mk(1,0,0,32'h1010,32'hA4, 1,0,4, 32'h1000,32'hA0));
    // drain in order
    vecs.push_back(mk(0,1,0,0,0, 1,0,4, 32'h1000,32'hA0));
    vecs.push_back(mk(0,1,0,0,0, 1,1,3, 32'h1004,32'hA1));
    vecs.push_back(mk(0,1,0,0,0, 1,1,2, 32'h1008,32'hA2));
    vecs.push_back(mk(0,1,0,0,0, 1,1,1, 32'h100C,32'hA3));
    vecs.push_back(mk(0,1,0,0,0, 0,1,0, 32'h0,32'h0));
    // streaming, 10 entries, pointers wrap twice
    for (int k = 0; k < 10; k++) begin
      logic [31:0] a, i, pa, pi;
      a = 32'h2000 + 32'(4*k); i = 32'hB0 + 32'(k);
      pa = 32'h2000 + 32'(4*(k-1)); pi = 32'hB0 + 32'(k-1);
      if (BYP)         vecs.push_back(mk(1,1,0,a,i, 1,1,0, a,i));
      else if (k == 0) vecs.push_back(mk(1,1,0,a,i, 0,1,0, 32'h0,32'h0));
      else             vecs.push_back(mk(1,1,0,a,i, 1,1,1, pa,pi));
    end
    if (BYP) vecs.push_back(mk(0,1,0,0,0, 0,1,0, 32'h0,32'h0));
    else     vecs.push_back(mk(0,1,0,0,0, 1,1,1, 32'h2024,32'hB9));
    vecs.push_back(mk(0,1,0,0,0, 0,1,0, 32'h0,32'h0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset valid_o", 64'(bus.valid_o), 64'd0);
    chk("reset ready_o", 64'(bus.ready_o), 64'd1);
    chk("reset count_o", 64'(bus.count_o), 64'd0);
    chk("reset instAddr_o", 64'(bus.instAddr_o), 64'd0);
    chk("reset inst_o", 64'(bus.inst_o), 64'd0);
    reset_n = 1'b1;

    foreach (vecs[n]) begin
      step(vecs[n].v, vecs[n].r, vecs[n].j, vecs[n].a, vecs[n].i);
      chk($sformatf("vec%0d valid_o", n), 64'(bus.valid_o), 64'(vecs[n].ev));
      chk($sformatf("vec%0d ready_o", n), 64'(bus.ready_o), 64'(vecs[n].er));
      chk($sformatf("vec%0d count_o", n), 64'(bus.count_o), 64'(vecs[n].ec));
      chk($sformatf("vec%0d instAddr_o", n), 64'(bus.instAddr_o), 64'(vecs[n].ea));
      chk($sformatf("vec%0d inst_o", n), 64'(bus.inst_o), 64'(vecs[n].ei));
      next();
    end

    // flush with 3 queued and an entry offered in the jump cycle
    step(1,0,0,32'h5000,32'hC0); next();
    step(1,0,0,32'h5004,32'hC1); next();
    step(1,0,0,32'h5008,32'hC2); next();
    step(1,1,1,32'h3000,32'hEE);
    chk("flush valid_o", 64'(bus.valid_o), 64'd0);
    chk("flush count_o before", 64'(bus.count_o), 64'd3);
    next();
    step(1,0,0,32'h4000,32'hF0);
    chk("flush count_o after", 64'(bus.count_o), 64'd0);
    chk("flush valid_o after", 64'(bus.valid_o), 64'(BYP));
    next();
    step(0,1,0,0,0);
    chk("post-jump valid_o", 64'(bus.valid_o), 64'd1);
    chk("post-jump count_o", 64'(bus.count_o), 64'd1);
    chk("post-jump instAddr_o", 64'(bus.instAddr_o), 64'h4000);
    chk("post-jump inst_o", 64'(bus.inst_o), 64'hF0);
    next();
    step(0,0,0,0,0);
    chk("post-jump drained", 64'(bus.count_o), 64'd0);
    next();

    // full with a same-cycle pop: the offer waits one cycle, no loss or duplicate
    for (int k = 0; k < 4; k++) begin
      step(1,0,0,32'h8000 + 32'(4*k),32'h90 + 32'(k)); next();
    end
    step(1,1,0,32'h8010,32'h94);
    chk("full pop ready_o", 64'(bus.ready_o), 64'd0);
    chk("full pop count_o", 64'(bus.count_o), 64'd4);
    next();
    step(1,0,0,32'h8010,32'h94);
    chk("after pop ready_o", 64'(bus.ready_o), 64'd1);
    chk("after pop count_o", 64'(bus.count_o), 64'd3);
    next();
    for (int k = 0; k < 4; k++) begin
      step(0,1,0,0,0);
      chk($sformatf("full drain%0d instAddr_o", k), 64'(bus.instAddr_o), 64'(32'h8004 + 32'(4*k)));
      chk($sformatf("full drain%0d count_o", k), 64'(bus.count_o), 64'(4-k));
      next();
    end
    step(0,0,0,0,0);
    chk("full drain empty", 64'(bus.valid_o), 64'd0);
    next();

    // asynchronous reset with 2 entries queued
    step(1,0,0,32'h6000,32'hD0); next();
    step(1,0,0,32'h6004,32'hD1); next();
    step(0,0,0,0,0);
    chk("pre-reset count_o", 64'(bus.count_o), 64'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset valid_o", 64'(bus.valid_o), 64'd0);
    chk("async reset count_o", 64'(bus.count_o), 64'd0);
    chk("async reset ready_o", 64'(bus.ready_o), 64'd1);
    #1 reset_n = 1'b1;
    post_reset = 1'b1;
    next();
    for (int k = 0; k < 3; k++) begin
      step(0,1,0,0,0);
      chk($sformatf("post-reset%0d valid_o", k), 64'(bus.valid_o), 64'd0);
      next();
    end

    // empty-queue latency
    step(1,1,0,32'h7000,32'hDEAD);
    chk("latency inst_o same cycle", 64'(bus.inst_o), BYP ? 64'hDEAD : 64'h0);
    chk("latency count_o same cycle", 64'(bus.count_o), 64'd0);
    next();
    step(0,1,0,0,0);
    chk("latency inst_o next cycle", 64'(bus.inst_o), BYP ? 64'h0 : 64'hDEAD);
    chk("latency valid_o next cycle", 64'(bus.valid_o), BYP ? 64'd0 : 64'd1);
    next();
    step(0,0,0,0,0);
    chk("latency drained", 64'(bus.count_o), 64'd0);
    next();

    chk("jump entry never output", 64'(seen_jump), 64'd0);
    chk("pre-reset entries never output", 64'(seen_old), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total + n_bound_fail);
    $finish;
  end
endmodule
